// File: rtl/banco_reg_file_pkg.sv
// Shared constants and types for the datapath register bank.
// Purely declarative: no logic, no latency.
// No flow control: these types carry no handshake.
package banco_reg_file_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage : banco_reg_file_pkg

// File: rtl/banco_reg_file.sv
// 32x32 register bank: two combinational read ports, one synchronous write port.
// Latency: reads zero-cycle; a write becomes visible the cycle after its clock edge (no bypass).
// Backpressure: none; a write is accepted on every rising edge where Regwrite is high.
module banco_reg_file
    import banco_reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] Writedata,
    input  logic              Regwrite,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    // Register 0 is ordinary storage; every address code maps to a real register.
    reg_data_t regs [NREGS];

    // Per-register write enable. Comparing against 1'b1 keeps an unknown
    // Regwrite from being treated as an enable by the decode.
    logic [NREGS-1:0] wr_en;

    // Decode the single write address into one-hot enables.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NREGS; i++) begin
            if ((Regwrite == 1'b1) && (WriteReg == reg_addr_t'(i))) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    // Storage: async clear on reset (which also beats a coincident write), else enabled write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= Writedata;
                end
            end
        end
    end

    // Read muxes: plain array lookups, no write-to-read forwarding.
    always_comb begin
        RD1 = regs[RR1];
        RD2 = regs[RR2];
    end

endmodule : banco_reg_file

// File: tb/tb_banco_reg_file.sv
// Directed bench for banco_reg_file with a queue-based scoreboard.
// Stimulus pushes expected read values and strobes a probe; the monitor pops and compares.
// No backpressure on the DUT; the probe strobe stands in for an output-valid.
module tb_banco_reg_file;
    import banco_reg_file_pkg::*;

    logic      clk;
    logic      rst_n;
    reg_addr_t RR1, RR2, WriteReg;
    reg_data_t Writedata;
    logic      Regwrite;
    reg_data_t RD1, RD2;

    banco_reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RR1       (RR1),
        .RR2       (RR2),
        .WriteReg  (WriteReg),
        .Writedata (Writedata),
        .Regwrite  (Regwrite),
        .RD1       (RD1),
        .RD2       (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string     name;
        reg_data_t e1;
        reg_data_t e2;
    } exp_t;

    exp_t      exp_q[$];
    event      probe_ev;
    int        n_cmp = 0;
    int        n_bad = 0;
    reg_data_t model [NREGS];

    // Monitor: on each probe strobe, drain the expectation queue against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(probe_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (RD1 !== e.e1) begin
                    n_bad++;
                    $display("FAIL %s RD1: got %h expected %h", e.name, RD1, e.e1);
                end
                n_cmp++;
                if (RD2 !== e.e2) begin
                    n_bad++;
                    $display("FAIL %s RD2: got %h expected %h", e.name, RD2, e.e2);
                end
            end
        end
    end

    // Queue an expectation, let combinational reads settle, then strobe the monitor.
    task automatic expect_rd(input string nm, input reg_data_t e1, input reg_data_t e2);
        exp_q.push_back('{nm, e1, e2});
        #1;
        ->probe_ev;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    // Drive a write at the falling edge and commit it on the next rising edge.
    task automatic do_write(input reg_addr_t a, input reg_data_t d);
        @(negedge clk);
        WriteReg  = a;
        Writedata = d;
        Regwrite  = 1'b1;
        @(posedge clk);
        model[a] = d;
        #1;
        Regwrite = 1'b0;
    endtask

    // Watchdog so the run always ends with a summary.
    initial begin
        #50000;
        n_bad++;
        $display("FAIL watchdog: stimulus did not complete, got timeout expected done");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst_n     = 1'b1;
        RR1       = '0;
        RR2       = '0;
        WriteReg  = '0;
        Writedata = '0;
        Regwrite  = 1'b0;
        clear_model();

        // Reset pulse between clock edges (edges at 5, 15, ...).
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        RR1 = 5'd9;  RR2 = 5'd4;
        expect_rd("reset_9_4", 32'd0, 32'd0);
        RR1 = 5'd16; RR2 = 5'd17;
        expect_rd("reset_16_17", 32'd0, 32'd0);

        // Write register 0 = 200: old value before the edge, new value after.
        @(negedge clk);
        RR1 = 5'd0; RR2 = 5'd1;
        WriteReg = 5'd0; Writedata = 32'd200; Regwrite = 1'b1;
        expect_rd("pre_edge_r0", 32'd0, 32'd0);
        @(posedge clk);
        model[0] = 32'd200;
        expect_rd("post_edge_r0", 32'd200, 32'd0);
        @(negedge clk);
        Regwrite = 1'b0; RR1 = 5'd0; RR2 = 5'd8;
        expect_rd("r0_r8", 32'd200, 32'd0);

        // Write disabled: several edges with data on the bus must not land.
        @(negedge clk);
        Regwrite = 1'b0; WriteReg = 5'd5; Writedata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        RR1 = 5'd5; RR2 = 5'd5;
        expect_rd("wr_disabled_r5", 32'd0, 32'd0);

        // Sweep: read-during-write shows the old value, then write i*0x01010101+7.
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            RR1 = reg_addr_t'(i); RR2 = reg_addr_t'(i);
            WriteReg = reg_addr_t'(i);
            Writedata = reg_data_t'(i) * 32'h01010101 + 32'd7;
            Regwrite = 1'b1;
            expect_rd($sformatf("rdw_old_%0d", i), model[i], model[i]);
            @(posedge clk);
            model[i] = reg_data_t'(i) * 32'h01010101 + 32'd7;
            #1;
            Regwrite = 1'b0;
        end
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            RR1 = reg_addr_t'(i); RR2 = reg_addr_t'(NREGS - 1 - i);
            expect_rd($sformatf("pair_%0d", i), model[i], model[NREGS-1-i]);
        end
        // Hand-computed spot checks of the sweep pattern.
        @(negedge clk);
        RR1 = 5'd0;  RR2 = 5'd31;
        expect_rd("sweep_hand_0_31", 32'h00000007, 32'h1F1F1F26);
        @(negedge clk);
        RR1 = 5'd10; RR2 = 5'd21;
        expect_rd("sweep_hand_10_21", 32'h0A0A0A11, 32'h1515151C);
        foreach (model[i]) begin
            if (i % 5 == 0) begin
                @(negedge clk);
                RR1 = reg_addr_t'(i); RR2 = reg_addr_t'(i);
                expect_rd($sformatf("same_addr_%0d", i), model[i], model[i]);
            end
        end

        // Async reset between edges: outputs drop at once and stay 0 across an edge.
        @(negedge clk);
        RR1 = 5'd3; RR2 = 5'd28;
        expect_rd("loaded_3_28", 32'h0303030A, 32'h1C1C1C23);
        rst_n = 1'b0;
        clear_model();
        expect_rd("async_reset_now", 32'd0, 32'd0);
        @(posedge clk);
        #1;
        expect_rd("async_reset_held", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset coincident with a write edge: reset wins.
        do_write(5'd10, 32'h00000055);
        @(negedge clk);
        RR1 = 5'd10; RR2 = 5'd11;
        expect_rd("r10_loaded", 32'h00000055, 32'd0);
        @(negedge clk);
        WriteReg = 5'd10; Writedata = 32'h0000AAAA; Regwrite = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        clear_model();
        #1;
        Regwrite = 1'b0;
        expect_rd("reset_vs_write", 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_rd("reset_vs_write_after", 32'd0, 32'd0);

        // Back-to-back overwrite of register 31.
        @(negedge clk);
        RR1 = 5'd31; RR2 = 5'd30;
        WriteReg = 5'd31; Writedata = 32'h00001234; Regwrite = 1'b1;
        @(posedge clk);
        #1;
        expect_rd("overwrite_first", 32'h00001234, 32'd0);
        Writedata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        Regwrite = 1'b0;
        expect_rd("overwrite_second", 32'hFFFFFFFF, 32'd0);

        // Every queued expectation must have been consumed by the monitor.
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_banco_reg_file

// File: doc/banco_reg_file.md
Name: banco_reg_file

Overview:
- General-purpose register bank for the datapath: 32 registers × 32 bits.
- Two independent combinational read ports (RR1→RD1, RR2→RD2) and one synchronous write port (WriteReg/Writedata, qualified by Regwrite).
- Sits between instruction decode (which supplies the register addresses) and the ALU/writeback stage.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, width of the register address ports.
- NREGS, 2**ADDR_W (32), number of registers. This value is derived, not overridden independently.

Ports:
- clk  input  1  single clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RR1  input  ADDR_W  read address, port 1.
- RR2  input  ADDR_W  read address, port 2.
- WriteReg  input  ADDR_W  write address.
- Writedata  input  DATA_W  write data.
- Regwrite  input  1  write enable, active high.
- RD1  output  DATA_W  contents of register RR1.
- RD2  output  DATA_W  contents of register RR2.

Behaviour:
- Storage: NREGS registers of DATA_W bits each.
- Reset:
  - When rst_n falls, all registers clear to 0 immediately, without waiting for clk.
  - They stay at 0 while rst_n is low.
  - RD1 and RD2 therefore read 0 during reset.
- Write:
  - On a rising edge of clk with rst_n high and Regwrite=1, register[WriteReg] <= Writedata.
  - With Regwrite=0, no register changes.
  - Only one register is written per cycle.
- Register 0 is an ordinary writable register. It is not hardwired to zero.
- Read:
  - RD1 = register[RR1] and RD2 = register[RR2], purely combinational with zero-cycle latency.
  - Outputs update in the same delta as an address change.
- Read-during-write (RRx == WriteReg, Regwrite=1):
  - No bypass. RDx shows the old value until the clock edge, then the new value.
  - The written value is visible on reads starting the cycle after the write edge.
- Identical addresses: RR1 == RR2 is legal; both outputs show the same register.
- Address range: every ADDR_W code is a valid register, so there is no out-of-range case.
- Reset mid-operation: reset asserted in the same cycle as a write wins. The register is 0 afterwards.
- X handling:
  - An X on Regwrite must not corrupt storage in synthesis. No specific simulation behaviour is required.
  - No other state or handshake exists.

Decomposition:
- Shared package holds:
  - the DATA_W and ADDR_W constants (32 and 5);
  - typedefs reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits).
- No sub-module. The storage array, write process and two read muxes live in a single module.

Test Plan:
- Reset: pulse rst_n low with no clk edge, then set RR1=9, RR2=4 → RD1=0, RD2=0. Repeat for addresses 16/17 → 0/0.
- Write then read:
  - Set RR1=0, RR2=1, WriteReg=0, Writedata=200, Regwrite=1. Before the edge RD1=0; after one rising edge RD1=200, RD2=0.
  - Then Regwrite=0, RR1=0, RR2=8 → RD1=200, RD2=0.
- Write disabled: Regwrite=0, WriteReg=5, Writedata=0xDEADBEEF, clock several edges, read RR1=5 → 0.
- Full sweep: write value i*0x01010101+7 to every register i = 0..31. Read back all pairs (i, 31-i) → exact values on both ports. Also check RR1=RR2=i gives identical outputs.
- Async reset mid-write: with registers loaded, assert rst_n low between edges → RD1 and RD2 drop to 0 immediately. Assert reset coincident with a Regwrite=1 edge → target register reads 0.
- Overwrite: write 0x1234 then 0xFFFFFFFF to register 31 on consecutive edges → RD shows 0x1234 after the first edge, 0xFFFFFFFF after the second.
